// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle subtractor: diff = a - b - bin over WIDTH-bit operands. It
// processes CHUNK bits per clock, starting with the least significant slice.
// The borrow between slices is held in a register. A start/busy/done
// handshake connects the block to a controlling FSM.
//
// Parameters
//   WIDTH  operand/result width; must be an integer multiple of CHUNK
//   CHUNK  bits subtracted per clock (1..WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; accepted only when busy=0 (IDLE or DONE)
//   a      minuend, sampled on the accepting edge
//   b      subtrahend, sampled on the accepting edge
//   bin    borrow-in, sampled on the accepting edge
//   busy   high while slices are being processed
//   done   one-cycle pulse; diff/bout (and ovf) are valid from this cycle
//   diff   a - b - bin modulo 2^WIDTH; holds until the next completion
//   bout   final borrow; 1 when a < b + bin (unsigned)
//   ovf    signed overflow flag (present only with SERIAL_SUBTRACTOR_OVF_EN)
//
// Optional feature
//   SERIAL_SUBTRACTOR_OVF_EN  adds the ovf output and its sign-tracking logic
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  // IW must be able to hold WIDTH itself, so that the CHUNK factor is not
  // truncated.
  localparam int unsigned IW     = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             r_sa;
  logic             r_sb;
`endif

  logic [IW-1:0]    w_base;
  logic [CHUNK-1:0] w_as;
  logic [CHUNK-1:0] w_bs;
  logic [CHUNK:0]   w_full;
  logic [WIDTH-1:0] w_res;
  logic             w_last;

  // Slice arithmetic is done in CHUNK+1 bits. The MSB is the borrow into the
  // next slice. The current slice is merged into a copy of the accumulator,
  // so the final slice can go straight to diff on the edge that enters DONE.
  always_comb begin
    w_base = IW'(r_cnt) * IW'(CHUNK);
    w_as   = r_a[w_base +: CHUNK];
    w_bs   = r_b[w_base +: CHUNK];
    w_full = {1'b0, w_as} - {1'b0, w_bs} - (CHUNK + 1)'(r_brw);
    w_res  = r_acc;
    w_res[w_base +: CHUNK] = w_full[CHUNK-1:0];
    w_last = (r_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_brw   <= bin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
`endif
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_acc <= w_res;
          r_brw <= w_full[CHUNK];
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= w_res;
            bout    <= w_full[CHUNK];
            r_state <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // w_full[CHUNK-1] is the result sign on the last slice.
            ovf     <= (r_sa ^ r_sb) & (w_full[CHUNK-1] ^ r_sa);
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NSLICE = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  serial_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation for every done pulse and also verifies how
  // many busy cycles preceded it.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 with diff=0x%0h expected no result", diff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("diff", 32'(diff), 32'(e.diff));
          check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          check("ovf", 32'(ovf), 32'(e.ovf));
`endif
          check("busy_cycles", 32'(busy_cnt), 32'(NSLICE));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.ovf  = ov;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < int'(NSLICE) + 4; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Issue one operation and scramble the inputs after the accept edge.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbin, input logic [WIDTH-1:0] ed,
                        input logic eb, input logic eo);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    push(ed, eb, eo);
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
    wait_done("done_timeout");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4A, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // start while busy must be ignored
    @(negedge clk);
    a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
    push(16'h00FF, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_timeout_ignore");
    repeat (NSLICE + 4) @(negedge clk);

    // back-to-back: start held during the DONE cycle
    @(negedge clk);
    a = 16'h0050; b = 16'h0020; bin = 1'b0; start = 1'b1;
    push(16'h0030, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done("done_timeout_b2b1");
    a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
    push(16'h000F, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("done_timeout_b2b2");

    // reset in the middle of an operation
    @(negedge clk);
    a = 16'h1111; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (NSLICE > 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NSLICE + 4) @(negedge clk);

    // normal operation resumes after the reset
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
